// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage and its consumers (decode reuses if_id_t).
// Holds the core widths, the NOP encoding, the FSM/IF-ID control enums and the IF/ID struct.
package fetch_stage_pkg;

    localparam int CORE_PC_WIDTH    = 16;
    localparam int CORE_INSTR_WIDTH = 16;
    localparam logic [CORE_INSTR_WIDTH-1:0] CORE_NOP_INSTR = 16'h0000;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

    // Per-edge action applied to the IF/ID register
    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE
    } if_id_op_e;

    typedef struct packed {
        logic                        valid;
        logic [CORE_INSTR_WIDTH-1:0] instr;
        logic [CORE_PC_WIDTH-1:0]    pc;
        logic [CORE_PC_WIDTH-1:0]    pc_plus2;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold, load and bubble controls.
// A bubble still records the PC pair so a squashed slot remains traceable.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = CORE_PC_WIDTH,
    parameter int                     INSTR_WIDTH = CORE_INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = CORE_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  if_id_op_e              op,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [PC_WIDTH-1:0]    pc_plus2,
    output logic                   valid_q,
    output logic [INSTR_WIDTH-1:0] instr_q,
    output logic [PC_WIDTH-1:0]    pc_q,
    output logic [PC_WIDTH-1:0]    pc_plus2_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus2_q <= '0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    valid_q    <= 1'b1;
                    instr_q    <= instr;
                    pc_q       <= pc;
                    pc_plus2_q <= pc_plus2;
                end
                IFID_BUBBLE: begin
                    valid_q    <= 1'b0;
                    instr_q    <= NOP_INSTR;
                    pc_q       <= pc;
                    pc_plus2_q <= pc_plus2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC (redirect/stall/flush),
// fills the IF/ID register and keeps a saturating count of valid fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = CORE_PC_WIDTH,
    parameter int                     INSTR_WIDTH = CORE_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = CORE_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
    output logic [15:0]            fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [15:0]           count_q;
    if_id_op_e             ifid_op;
    logic                  unused_target_lsb;

    assign imem_pc           = pc_q;
    assign pc_inc            = pc_q + PC_WIDTH'(2);
    // Instructions are halfword aligned, so the target LSB is dropped
    assign redirect_pc       = {redirect_target[PC_WIDTH-1:1], 1'b0};
    assign unused_target_lsb = redirect_target[0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_op = IFID_HOLD;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                ifid_op = IFID_BUBBLE;
                if (redirect_valid) pc_d = redirect_pc;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    ifid_op = IFID_BUBBLE;
                end else if (stall && flush) begin
                    ifid_op = IFID_BUBBLE;
                end else if (stall) begin
                    ifid_op = IFID_HOLD;
                end else if (flush) begin
                    pc_d    = pc_inc;
                    ifid_op = IFID_BUBBLE;
                end else begin
                    pc_d    = pc_inc;
                    ifid_op = IFID_LOAD;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ifid_op == IFID_LOAD && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (ifid_op),
        .instr     (imem_instr),
        .pc        (pc_q),
        .pc_plus2  (pc_inc),
        .valid_q   (if_id_valid),
        .instr_q   (if_id_instr),
        .pc_q      (if_id_pc),
        .pc_plus2_q(if_id_pc_plus2)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks boot, stall, flush, redirect and wrap,
// then hand sequences cover async reset, redirect during BOOT and count saturation.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic        if_id_valid;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus2, fetch_count;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc_p1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign pc_p1      = imem_pc + 16'd1;
    assign imem_instr = {mem[pc_p1], mem[imem_pc]};

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [15:0] tgt;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic [15:0] ipc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic v, input logic [15:0] ins, input logic [15:0] pc,
                           input logic [15:0] pc2, input logic [15:0] ipc, input logic [15:0] cnt);
        chk("valid", idx, {15'd0, if_id_valid}, {15'd0, v});
        chk("instr", idx, if_id_instr, ins);
        chk("if_id_pc", idx, if_id_pc, pc);
        chk("pc_plus2", idx, if_id_pc_plus2, pc2);
        chk("imem_pc", idx, imem_pc, ipc);
        chk("fetch_count", idx, fetch_count, cnt);
    endtask

    task automatic set_in(input logic s, input logic f, input logic r, input logic [15:0] t);
        stall = s; flush = f; redirect_valid = r; redirect_target = t;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'hAA; mem[16'h0001] = 8'h3C;
        mem[16'h0002] = 8'h98; mem[16'h0003] = 8'h12;
        mem[16'h0004] = 8'h11; mem[16'h0005] = 8'h11;
        mem[16'h0006] = 8'h22; mem[16'h0007] = 8'h22;
        mem[16'h0008] = 8'h33; mem[16'h0009] = 8'h33;
        mem[16'h000A] = 8'h44; mem[16'h000B] = 8'h44;
        mem[16'hFFFE] = 8'h7E; mem[16'hFFFF] = 8'h7F;

        //              stall flush redir tgt       valid instr     pc        pc2       imem_pc   count
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'd0}; // BOOT
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3CAA, 16'h0000, 16'h0002, 16'h0002, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1298, 16'h0002, 16'h0004, 16'h0004, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1298, 16'h0002, 16'h0004, 16'h0004, 16'd2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1298, 16'h0002, 16'h0004, 16'h0004, 16'd2};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1298, 16'h0002, 16'h0004, 16'h0004, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0004, 16'h0006, 16'h0006, 16'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006, 16'h0008, 16'h0008, 16'd3}; // flush
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000, 16'h0008, 16'h000A, 16'h0006, 16'd3}; // back to 6
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006, 16'h0008, 16'h0006, 16'd3}; // stall+flush
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h0006, 16'h0008, 16'h0008, 16'd4};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h000B, 1'b0, 16'h0000, 16'h0008, 16'h000A, 16'h000A, 16'd4}; // odd target
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 16'h000A, 16'h000C, 16'h000C, 16'd5};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h000C, 16'h000E, 16'hFFFE, 16'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7F7E, 16'hFFFE, 16'h0000, 16'h0000, 16'd6}; // wrap
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3CAA, 16'h0000, 16'h0002, 16'h0002, 16'd7};

        #2;
        chk_all(100, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            set_in(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].tgt);
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].pc2, vecs[i].ipc, vecs[i].cnt);
        end

        // Asynchronous reset mid-cycle takes effect before the next edge
        #1 rst_n = 1'b0;
        #1;
        chk_all(200, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0);

        // BOOT honours only the redirect: stall is ignored and the target is aligned
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 16'h0005);
        @(posedge clk);
        #1;
        chk_all(201, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h0004, 16'd0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk_all(202, 1'b1, 16'h1111, 16'h0004, 16'h0006, 16'h0006, 16'd1);

        // Saturation: reset, BOOT, then free-run until the count sits at 0xFFFE
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 0, fetch_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("sat", i, fetch_count, 16'hFFFF);
        end

        #1 rst_n = 1'b0;
        #1;
        chk("count_reset", 0, fetch_count, 16'h0000);
        chk("valid_reset", 0, {15'd0, if_id_valid}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined RISC core.
- Owns the program counter and drives it combinationally to the byte-addressable instruction memory.
- Captures the returned 16-bit instruction into the IF/ID pipeline register.
- Handles stall, flush and redirect from branch/jump resolution, and keeps a saturating fetch counter for debug.

Parameters:
- PC_WIDTH, 16, width of PC and all address ports
- INSTR_WIDTH, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, encoding written into IF/ID on a bubble

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_pc  out  PC_WIDTH  byte address to instruction memory; equals pc_q combinationally
- imem_instr  in  INSTR_WIDTH  instruction word returned combinationally for imem_pc
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  hazard unit: replace IF/ID contents with a bubble
- redirect_valid  in  1  branch taken or jump resolved this cycle
- redirect_target  in  PC_WIDTH  next PC when redirect_valid=1
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_WIDTH  latched instruction
- if_id_pc  out  PC_WIDTH  address of the latched instruction
- if_id_pc_plus2  out  PC_WIDTH  if_id_pc+2, used as the link/return address
- fetch_count  out  16  number of valid instructions latched, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_q=RESET_PC, state=BOOT.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus2=0, fetch_count=0.
- FSM: BOOT, RUN.
  - BOOT lasts exactly one clock after reset release.
  - In BOOT: PC does not advance, IF/ID is loaded with a bubble, then state goes to RUN.
  - BOOT ignores stall, flush and redirect, except that redirect_valid in BOOT loads the target into pc_q.
- RUN, per rising edge, evaluated in priority order:
  1. redirect_valid=1:
     - pc_q <= {redirect_target[PC_WIDTH-1:1],1'b0}. Bit 0 is forced to 0 because instructions are 2-byte aligned.
     - IF/ID <= bubble, regardless of stall or flush.
  2. stall=1 and flush=1: pc_q holds; IF/ID <= bubble.
  3. stall=1: pc_q and all IF/ID fields hold their values.
  4. flush=1: pc_q <= pc_q+2; IF/ID <= bubble.
  5. Otherwise:
     - pc_q <= pc_q+2.
     - IF/ID <= {valid=1, instr=imem_instr, pc=pc_q, pc_plus2=pc_q+2}.
- Bubble definition: if_id_valid=0, if_id_instr=NOP_INSTR. if_id_pc and if_id_pc_plus2 are loaded with the current pc_q and pc_q+2 so the values stay traceable.
- Arithmetic:
  - PC increment is modulo 2^PC_WIDTH: 16'hFFFE+2 = 16'h0000, with no flag.
  - if_id_pc_plus2 wraps the same way.
- Instruction byte order: imem_instr = {mem[pc+1], mem[pc]}. The stage latches it unchanged.
- fetch_count:
  - Increments by 1 on each edge where IF/ID is loaded with valid=1 (case 5 only).
  - Saturates at 16'hFFFF; never wraps.
- Latency: instruction at address A appears on if_id_instr one clock after pc_q=A, provided the stage is not stalled.
- Reset asserted mid-operation: all state returns to reset values immediately. The BOOT cycle repeats after release.
- Stall held for N cycles: IF/ID is stable for N cycles and no instruction is lost or duplicated.

Decomposition:
- Shared core package holds:
  - PC_WIDTH and INSTR_WIDTH constants
  - NOP_INSTR encoding
  - the fetch FSM state enum (BOOT, RUN)
  - an if_id_t struct {valid, instr, pc, pc_plus2} for reuse by the decode stage
- One natural sub-module: if_id_reg. It holds the IF/ID register with load, hold and bubble controls.
- Next-PC selection and the FSM stay in fetch_stage.

Test Plan:
- Reset, memory preloaded with 0x3CAA at bytes 0/1 and 0x1298 at bytes 2/3:
  - BOOT cycle gives if_id_valid=0.
  - Next edge: if_id_instr=0x3CAA, if_id_pc=0, if_id_pc_plus2=2.
  - Following edge: 0x1298, pc=2; fetch_count=2.
- Stall high for 3 cycles at pc_q=4: imem_pc stays 4 and IF/ID is unchanged for 3 cycles. On release, the instruction at 4 is latched exactly once.
- redirect_valid with target 0x000B while stall=1: pc_q becomes 0x000A and if_id_valid=0. The next edge latches mem[0x0A..0x0B] with if_id_pc=0x000A.
- Flush alone at pc_q=6: IF/ID becomes a bubble (instr=NOP_INSTR) and pc_q becomes 8. Flush with stall at pc_q=6: bubble, pc_q stays 6.
- Force pc_q=0xFFFE via redirect, run 2 cycles: if_id_pc=0xFFFE, if_id_pc_plus2=0x0000, next pc_q=0x0000.
- Preload fetch_count to 0xFFFE (or run long) and fetch 3 valid instructions: count sticks at 0xFFFF. Assert rst_n=0 asynchronously mid-cycle: all outputs return to reset values before the next edge.
